// File: rtl/rx_frame_deframer.sv
// Receive-side deframer: drains the FT245 RX FIFO, validates and strips frame
// headers, and streams payload words with channel/last tags over valid/ready.
module rx_frame_deframer #(
  parameter logic [15:0] SYNC    = 16'hA55A,
  parameter int          MAX_LEN = 1024,
  parameter int          CNT_W   = 16
) (
  input  logic             usb_clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             rx_fifo_empty,
  input  logic [31:0]      rx_fifo_data,
  output logic             rx_fifo_read,
  output logic [31:0]      m_data,
  output logic [3:0]       m_chan,
  output logic             m_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] sync_err_cnt,
  output logic [CNT_W-1:0] len_err_cnt
);

  typedef enum logic {ST_HDR, ST_PAYLOAD} state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  chan;
    logic        last;
  } beat_t;

  localparam logic [11:0] MAX_LEN_L = 12'(MAX_LEN);

  state_e           state_q, state_d;
  logic [3:0]       chan_q, chan_d;
  logic [11:0]      rem_q, rem_d;
  logic [CNT_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0] sync_err_q, sync_err_d;
  logic [CNT_W-1:0] len_err_q, len_err_d;
  logic             inflight_q;
  beat_t            buf_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       occ_q;

  logic        pop_req, pop, arrive, push;
  logic [2:0]  level, limit;
  logic [15:0] hdr_sync;
  logic [3:0]  hdr_chan;
  logic [11:0] hdr_len;

  assign hdr_sync = rx_fifo_data[31:16];
  assign hdr_chan = rx_fifo_data[15:12];
  assign hdr_len  = rx_fifo_data[11:0];

  assign m_valid = (occ_q != 2'd0);
  assign pop_req = m_valid && m_ready;
  assign pop     = pop_req && !flush;
  assign arrive  = inflight_q && !flush;
  assign push    = arrive && (state_q == ST_PAYLOAD);

  // Buffered words plus the one in flight may not exceed the 2-entry buffer.
  assign level = {1'b0, occ_q} + {2'b0, inflight_q};
  assign limit = 3'd2 + {2'b0, pop_req};
  // Gated by rst_n so no FIFO word is consumed while the block is held in reset.
  assign rx_fifo_read = rst_n && !rx_fifo_empty && !flush && (level < limit);

  assign m_data       = buf_q[rd_ptr_q].data;
  assign m_chan       = buf_q[rd_ptr_q].chan;
  assign m_last       = buf_q[rd_ptr_q].last;
  assign busy         = (state_q == ST_PAYLOAD);
  assign frame_cnt    = frame_q;
  assign sync_err_cnt = sync_err_q;
  assign len_err_cnt  = len_err_q;

  always_comb begin
    // NOTE: every variable takes its hold value first so no branch can infer a latch.
    state_d    = state_q;
    chan_d     = chan_q;
    rem_d      = rem_q;
    frame_d    = frame_q;
    sync_err_d = sync_err_q;
    len_err_d  = len_err_q;
    if (flush) begin
      state_d = ST_HDR;
    end else if (arrive) begin
      case (state_q)
        ST_HDR: begin
          if (hdr_sync != SYNC) begin
            if (sync_err_q != '1) sync_err_d = sync_err_q + 1'b1;
          end else if (hdr_len == 12'd0 || hdr_len > MAX_LEN_L) begin
            if (len_err_q != '1) len_err_d = len_err_q + 1'b1;
          end else begin
            chan_d  = hdr_chan;
            rem_d   = hdr_len;
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          rem_d = rem_q - 12'd1;
          if (rem_q == 12'd1) begin
            frame_d = frame_q + 1'b1;
            state_d = ST_HDR;
          end
        end
        default: state_d = ST_HDR;
      endcase
    end
  end

  always_ff @(posedge usb_clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (!rst_n) begin
      state_q    <= ST_HDR;
      chan_q     <= 4'd0;
      rem_q      <= 12'd0;
      frame_q    <= '0;
      sync_err_q <= '0;
      len_err_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      rem_q      <= rem_d;
      frame_q    <= frame_d;
      sync_err_q <= sync_err_d;
      len_err_q  <= len_err_d;
      inflight_q <= rx_fifo_read;
    end
  end

  always_ff @(posedge usb_clk or negedge rst_n) begin
    // NOTE: the buffer entries are reset as well, so m_data/m_chan/m_last read 0 out of reset.
    if (!rst_n) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= {rx_fifo_data, chan_q, rem_q == 12'd1};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // The read-issue rule makes overflow impossible; this guards that claim.
  assert property (@(posedge usb_clk) disable iff (!rst_n) occ_q <= 2'd2);

endmodule

// File: tb/tb_rx_frame_deframer.sv
// Self-checking bench for rx_frame_deframer: FIFO model feeding the DUT, expected
// beats queued at stimulus time and compared against beats accepted downstream.
module tb_rx_frame_deframer;

  localparam int CNT_W   = 4;
  localparam int MAX_LEN = 1024;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  chan;
    logic        last;
  } beat_t;

  logic             usb_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             rx_fifo_empty = 1'b1;
  logic [31:0]      rx_fifo_data = 32'd0;
  logic             rx_fifo_read;
  logic [31:0]      m_data;
  logic [3:0]       m_chan;
  logic             m_last;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt, sync_err_cnt, len_err_cnt;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int rd_empty_err = 0;
  int exp_frames = 0, exp_sync = 0, exp_len = 0;

  logic [31:0] fifo_q[$];
  beat_t       exp_q[$];
  beat_t       obs_q[$];
  int          obs_cyc[$];
  logic        rd_log[$];
  logic        cur_valid;
  beat_t       cur_beat;

  rx_frame_deframer #(.SYNC(16'hA55A), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .usb_clk(usb_clk), .rst_n(rst_n), .flush(flush),
    .rx_fifo_empty(rx_fifo_empty), .rx_fifo_data(rx_fifo_data), .rx_fifo_read(rx_fifo_read),
    .m_data(m_data), .m_chan(m_chan), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .frame_cnt(frame_cnt), .sync_err_cnt(sync_err_cnt), .len_err_cnt(len_err_cnt)
  );

  always #5 usb_clk = ~usb_clk;

  // Standard (non-FWFT) FIFO: data appears the cycle after the read strobe.
  always @(posedge usb_clk) begin
    if (rx_fifo_read) begin
      if (fifo_q.size() == 0) rd_empty_err++;
      else rx_fifo_data <= fifo_q.pop_front();
    end
    rx_fifo_empty <= (fifo_q.size() == 0);
  end

  function automatic beat_t mk(input logic [31:0] d, input logic [3:0] c, input logic l);
    return {d, c, l};
  endfunction

  task automatic clear_logs();
    exp_q.delete(); obs_q.delete(); obs_cyc.delete(); rd_log.delete();
  endtask

  // One clock: drive at the falling edge, sample 1ns later; a beat is recorded
  // when it will be accepted at the coming rising edge.
  task automatic cycle(input logic r, input logic f);
    @(negedge usb_clk);
    m_ready = r;
    flush = f;
    #1;
    cyc_n++;
    cur_valid = m_valid;
    cur_beat = {m_data, m_chan, m_last};
    rd_log.push_back(rx_fifo_read);
    if (m_valid && r && !f) begin
      obs_q.push_back(cur_beat);
      obs_cyc.push_back(cyc_n);
    end
  endtask

  task automatic drain(input int max_cyc, output bit timed_out);
    int n = 0;
    bit done = 0;
    while (!done && n < max_cyc) begin
      cycle(1'b1, 1'b0);
      n++;
      done = (fifo_q.size() == 0) && !cur_valid && (obs_q.size() >= exp_q.size());
    end
    timed_out = !done;
    repeat (3) cycle(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge usb_clk);
    #1;
    checks++;
    if ({m_valid, m_last, m_chan, m_data, busy, rx_fifo_read} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {m_valid, m_last, m_chan, m_data, busy, rx_fifo_read});
    end
    checks++;
    if ({frame_cnt, sync_err_cnt, len_err_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_counters got=%h exp=0", {frame_cnt, sync_err_cnt, len_err_cnt});
    end
    @(negedge usb_clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || rx_fifo_read !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle valid=%b busy=%b rd=%b exp=0/0/0", m_valid, busy, rx_fifo_read);
    end
  endtask

  task automatic test_streaming();
    beat_t e, o;
    bit to;
    int first = -1, ones = 0, run = 0;
    clear_logs();
    fifo_q.push_back(32'hA55A_3003);
    fifo_q.push_back(32'h11); fifo_q.push_back(32'h22); fifo_q.push_back(32'h33);
    exp_q.push_back(mk(32'h11, 4'd3, 1'b0));
    exp_q.push_back(mk(32'h22, 4'd3, 1'b0));
    exp_q.push_back(mk(32'h33, 4'd3, 1'b1));
    exp_frames++;
    drain(40, to);
    checks++;
    if (to) begin failures++; $display("FAIL stream_timeout got=timeout exp=drained"); end
    checks++;
    if (obs_cyc.size() != 3 || obs_cyc[1] != obs_cyc[0] + 1 || obs_cyc[2] != obs_cyc[1] + 1) begin
      failures++;
      $display("FAIL stream_consecutive got=%0d beats non-consecutive exp=3 back-to-back", obs_cyc.size());
    end
    foreach (rd_log[i]) if (rd_log[i]) begin ones++; if (first < 0) first = i; end
    if (first >= 0) for (int i = first; i < rd_log.size() && rd_log[i]; i++) run++;
    checks++;
    if (ones != 4 || run != 4) begin
      failures++;
      $display("FAIL stream_reads got=%0d total/%0d run exp=4/4", ones, run);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL stream_beat got=%h exp=%h", o, e); end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++; $display("FAIL stream_count got=%0d/%0d leftover exp=0/0", exp_q.size(), obs_q.size());
    end
    checks++;
    if (frame_cnt !== CNT_W'(exp_frames) || busy !== 1'b0) begin
      failures++; $display("FAIL stream_frame_cnt got=%0d busy=%b exp=%0d busy=0", frame_cnt, busy, exp_frames);
    end
  endtask

  task automatic test_backpressure();
    beat_t e, o, prev_beat;
    bit [3:0] pat = 4'b1001;
    logic r;
    bit prev_stall = 0;
    int reads = 0, pops = 0, lvl;
    clear_logs();
    fifo_q.push_back(32'hA55A_3003);
    fifo_q.push_back(32'h11); fifo_q.push_back(32'h22); fifo_q.push_back(32'h33);
    exp_q.push_back(mk(32'h11, 4'd3, 1'b0));
    exp_q.push_back(mk(32'h22, 4'd3, 1'b0));
    exp_q.push_back(mk(32'h33, 4'd3, 1'b1));
    exp_frames++;
    for (int i = 0; i < 40; i++) begin
      r = pat[i % 4];
      cycle(r, 1'b0);
      if (prev_stall) begin
        checks++;
        if (cur_valid !== 1'b1 || cur_beat !== prev_beat) begin
          failures++; $display("FAIL bp_hold got=%b/%h exp=1/%h", cur_valid, cur_beat, prev_beat);
        end
      end
      if (rd_log[$]) reads++;
      if (cur_valid && r) pops++;
      lvl = reads - pops - ((reads >= 2) ? 1 : 0);
      checks++;
      if (lvl > 2) begin failures++; $display("FAIL bp_occupancy got=%0d exp<=2", lvl); end
      prev_stall = cur_valid && !r;
      prev_beat = cur_beat;
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL bp_beat got=%h exp=%h", o, e); end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++; $display("FAIL bp_count got=%0d/%0d leftover exp=0/0", exp_q.size(), obs_q.size());
    end
    checks++;
    if (frame_cnt !== CNT_W'(exp_frames)) begin
      failures++; $display("FAIL bp_frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_bad_headers();
    beat_t e, o;
    bit to;
    clear_logs();
    fifo_q.push_back(32'h1234_0002);
    fifo_q.push_back(32'hA55A_0000);
    fifo_q.push_back(32'hA55A_0FFF);
    fifo_q.push_back(32'hA55A_1001);
    fifo_q.push_back(32'h77);
    exp_q.push_back(mk(32'h77, 4'd1, 1'b1));
    exp_sync += 1; exp_len += 2; exp_frames++;
    drain(40, to);
    checks++;
    if (to) begin failures++; $display("FAIL badhdr_timeout got=timeout exp=drained"); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL badhdr_beat got=%h exp=%h", o, e); end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++; $display("FAIL badhdr_count got=%0d/%0d leftover exp=0/0", exp_q.size(), obs_q.size());
    end
    checks++;
    if (sync_err_cnt !== CNT_W'(exp_sync) || len_err_cnt !== CNT_W'(exp_len)) begin
      failures++;
      $display("FAIL badhdr_counters got=%0d/%0d exp=%0d/%0d", sync_err_cnt, len_err_cnt, exp_sync, exp_len);
    end
  endtask

  task automatic test_back_to_back();
    beat_t e, o;
    bit to;
    int first = -1, ones = 0, run = 0;
    clear_logs();
    fifo_q.push_back(32'hA55A_2001); fifo_q.push_back(32'hAA);
    fifo_q.push_back(32'hA55A_5002); fifo_q.push_back(32'hBB); fifo_q.push_back(32'hCC);
    exp_q.push_back(mk(32'hAA, 4'd2, 1'b1));
    exp_q.push_back(mk(32'hBB, 4'd5, 1'b0));
    exp_q.push_back(mk(32'hCC, 4'd5, 1'b1));
    exp_frames += 2;
    drain(40, to);
    checks++;
    if (to) begin failures++; $display("FAIL b2b_timeout got=timeout exp=drained"); end
    foreach (rd_log[i]) if (rd_log[i]) begin ones++; if (first < 0) first = i; end
    if (first >= 0) for (int i = first; i < rd_log.size() && rd_log[i]; i++) run++;
    checks++;
    if (ones != 5 || run != 5 || obs_cyc.size() != 3 || obs_cyc[2] != obs_cyc[1] + 1) begin
      failures++; $display("FAIL b2b_no_bubble got=%0d reads/%0d run exp=5/5 with BB,CC adjacent", ones, run);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL b2b_beat got=%h exp=%h", o, e); end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0 || frame_cnt !== CNT_W'(exp_frames)) begin
      failures++;
      $display("FAIL b2b_count got=%0d/%0d frames=%0d exp=0/0 frames=%0d", exp_q.size(), obs_q.size(), frame_cnt, exp_frames);
    end
  endtask

  task automatic test_len_boundary();
    beat_t e, o;
    bit to;
    int bad = 0;
    clear_logs();
    fifo_q.push_back(32'hA55A_0401);
    fifo_q.push_back(32'hA55A_0400);
    for (int i = 0; i < MAX_LEN; i++) begin
      fifo_q.push_back(32'h1000_0000 + i);
      exp_q.push_back(mk(32'h1000_0000 + i, 4'd0, i == MAX_LEN - 1));
    end
    exp_len++; exp_frames++;
    drain(3000, to);
    checks++;
    if (to) begin failures++; $display("FAIL maxlen_timeout got=timeout exp=drained"); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++; bad++;
        if (bad <= 4) $display("FAIL maxlen_beat got=%h exp=%h", o, e);
      end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0 || len_err_cnt !== CNT_W'(exp_len)) begin
      failures++;
      $display("FAIL maxlen_count got=%0d/%0d len_err=%0d exp=0/0 len_err=%0d", exp_q.size(), obs_q.size(), len_err_cnt, exp_len);
    end
  endtask

  task automatic test_counters();
    beat_t e, o;
    bit to;
    clear_logs();
    for (int i = 0; i < 20; i++) fifo_q.push_back(32'h0000_0100 + i);
    for (int i = 0; i < 20; i++) fifo_q.push_back(32'hA55A_0000);
    for (int i = 0; i < 16; i++) begin
      fifo_q.push_back(32'hA55A_1001);
      fifo_q.push_back(32'h2000_0000 + i);
      exp_q.push_back(mk(32'h2000_0000 + i, 4'd1, 1'b1));
    end
    exp_sync = (exp_sync + 20 > CNT_MAX) ? CNT_MAX : exp_sync + 20;
    exp_len  = (exp_len + 20 > CNT_MAX) ? CNT_MAX : exp_len + 20;
    exp_frames += 16;
    drain(300, to);
    checks++;
    if (to) begin failures++; $display("FAIL cnt_timeout got=timeout exp=drained"); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL cnt_beat got=%h exp=%h", o, e); end
    end
    checks++;
    if (sync_err_cnt !== CNT_W'(exp_sync)) begin
      failures++; $display("FAIL cnt_sync_saturate got=%0d exp=%0d", sync_err_cnt, exp_sync);
    end
    checks++;
    if (len_err_cnt !== CNT_W'(exp_len)) begin
      failures++; $display("FAIL cnt_len_saturate got=%0d exp=%0d", len_err_cnt, exp_len);
    end
    checks++;
    if (frame_cnt !== CNT_W'(exp_frames)) begin
      failures++; $display("FAIL cnt_frame_wrap got=%0d exp=%0d", frame_cnt, exp_frames % (CNT_MAX + 1));
    end
  endtask

  task automatic test_flush();
    beat_t e, o;
    bit to;
    int n;
    clear_logs();
    fifo_q.push_back(32'hA55A_7004);
    fifo_q.push_back(32'h1111); fifo_q.push_back(32'h2222);
    exp_q.push_back(mk(32'h1111, 4'd7, 1'b0));
    exp_q.push_back(mk(32'h2222, 4'd7, 1'b0));
    drain(40, to);
    fifo_q.push_back(32'h3333);
    n = 0;
    do begin cycle(1'b1, 1'b0); n++; end while (!rd_log[$] && n < 10);
    checks++;
    if (!rd_log[$] || to) begin failures++; $display("FAIL flush_setup got=rd %b exp=read in flight", rd_log[$]); end
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    checks++;
    if (cur_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL flush_inflight got=valid %b busy %b exp=0/0", cur_valid, busy);
    end
    fifo_q.push_back(32'hA55A_9001); fifo_q.push_back(32'h4444);
    exp_q.push_back(mk(32'h4444, 4'd9, 1'b1));
    exp_frames++;
    drain(40, to);
    fifo_q.push_back(32'hA55A_6002); fifo_q.push_back(32'h5555);
    n = 0;
    do begin cycle(1'b0, 1'b0); n++; end while (!cur_valid && n < 15);
    checks++;
    if (cur_valid !== 1'b1 || cur_beat !== mk(32'h5555, 4'd6, 1'b0) || to) begin
      failures++; $display("FAIL flush_hold_setup got=%b/%h exp=1/%h", cur_valid, cur_beat, mk(32'h5555, 4'd6, 1'b0));
    end
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    checks++;
    if (cur_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL flush_valid_drop got=valid %b busy %b exp=0/0", cur_valid, busy);
    end
    fifo_q.push_back(32'hA55A_0001); fifo_q.push_back(32'h6666);
    exp_q.push_back(mk(32'h6666, 4'd0, 1'b1));
    exp_frames++;
    drain(40, to);
    checks++;
    if (to) begin failures++; $display("FAIL flush_timeout got=timeout exp=drained"); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL flush_beat got=%h exp=%h", o, e); end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0 || frame_cnt !== CNT_W'(exp_frames)) begin
      failures++;
      $display("FAIL flush_count got=%0d/%0d frames=%0d exp=0/0 frames=%0d", exp_q.size(), obs_q.size(), frame_cnt, exp_frames % (CNT_MAX + 1));
    end
  endtask

  task automatic test_async_reset();
    beat_t e, o;
    bit to;
    int n = 0;
    clear_logs();
    fifo_q.push_back(32'hA55A_3003);
    fifo_q.push_back(32'hA1); fifo_q.push_back(32'hB2); fifo_q.push_back(32'hC3);
    do begin cycle(1'b0, 1'b0); n++; end while (!cur_valid && n < 20);
    repeat (3) cycle(1'b0, 1'b0);
    checks++;
    if (cur_valid !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL areset_setup got=valid %b busy %b exp=1/1", cur_valid, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_last, m_chan, m_data, busy, rx_fifo_read} !== '0) begin
      failures++;
      $display("FAIL areset_outputs got=%h exp=0", {m_valid, m_last, m_chan, m_data, busy, rx_fifo_read});
    end
    checks++;
    if ({frame_cnt, sync_err_cnt, len_err_cnt} !== '0) begin
      failures++; $display("FAIL areset_counters got=%h exp=0", {frame_cnt, sync_err_cnt, len_err_cnt});
    end
    fifo_q.delete();
    repeat (3) cycle(1'b0, 1'b0);
    rst_n = 1'b1;
    exp_frames = 0; exp_sync = 0; exp_len = 0;
    clear_logs();
    fifo_q.push_back(32'hA55A_0001); fifo_q.push_back(32'h5);
    exp_q.push_back(mk(32'h5, 4'd0, 1'b1));
    exp_frames++;
    drain(40, to);
    checks++;
    if (to) begin failures++; $display("FAIL areset_timeout got=timeout exp=drained"); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL areset_beat got=%h exp=%h", o, e); end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0 || frame_cnt !== CNT_W'(exp_frames)) begin
      failures++;
      $display("FAIL areset_count got=%0d/%0d frames=%0d exp=0/0 frames=%0d", exp_q.size(), obs_q.size(), frame_cnt, exp_frames);
    end
  endtask

  task automatic test_fifo_protocol();
    checks++;
    if (rd_empty_err != 0) begin
      failures++; $display("FAIL read_while_empty got=%0d exp=0", rd_empty_err);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bad_headers();
    test_back_to_back();
    test_len_boundary();
    test_counters();
    test_flush();
    test_async_reset();
    test_fifo_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
